// File: rtl/z80db_pkg.sv
// Shared types and constants for the Z80 debug-board cache controller.
// Holds the FSM state encoding, default port addresses and control-bit indices.
package z80db_pkg;

   typedef enum logic [1:0] {
      ST_ROM     = 2'b00,
      ST_ARM_ON  = 2'b01,
      ST_CACHE   = 2'b10,
      ST_ARM_OFF = 2'b11
   } state_t;

   localparam logic [7:0] DEF_CTRL_PORT = 8'hFB;
   localparam logic [7:0] DEF_PAGE_PORT = 8'hFD;

   localparam int CTL_EN = 0;
   localparam int CTL_WP = 1;

endpackage

// File: rtl/z80_sync_edge.sv
// Multi-stage synchroniser for one active-low Z80 strobe, with edge pulses.
// Ports: i_clk, i_rst_n, i_d (raw) -> o_q (synced), o_rise, o_fall (1-clk pulses).
module z80_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   // Flops reset to 1 so an idle strobe produces no edge after reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_q    = r_sync[STAGES-1];
   assign o_rise = o_q & ~r_prev;
   assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/z80_cache_ctl.sv
// Z80 debug-board cache/ROM-block controller: paging + control ports, SRAM strobes.
// Ports: Z80 bus in (mreq_n..d_in), readback d_out/d_oe, SRAM moe/mwe/mce/mbank, romblk, cache_on.
module z80_cache_ctl
   import z80db_pkg::*;
#(
   parameter int         BANK_W         = 1,
   parameter logic [7:0] CTRL_PORT      = DEF_CTRL_PORT,
   parameter logic [7:0] PAGE_PORT      = DEF_PAGE_PORT,
   parameter bit         CACHE_ON_RESET = 1'b0,
   parameter int         SYNC_STAGES    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mreq_n,
   input  logic              iorq_n,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic [7:0]        a,
   input  logic              a14,
   input  logic              a15,
   input  logic [7:0]        d_in,
   output logic [7:0]        d_out,
   output logic              d_oe,
   input  logic              bsrq,
   input  logic              jump,
   output logic              moe,
   output logic              mwe,
   output logic              mce,
   output logic [BANK_W-1:0] mbank,
   output logic              romblk,
   output logic              cache_on
);

   localparam state_t RST_ST = CACHE_ON_RESET ? ST_CACHE : ST_ROM;

   logic w_iorq_s, w_iorq_rise, w_iorq_fall;
   logic w_rd_s, w_rd_rise, w_rd_fall;
   logic w_wr_s, w_wr_rise, w_wr_fall;
   logic w_mreq_s, w_mreq_rise, w_mreq_fall;

   z80_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_iorq (
      .i_clk(clk), .i_rst_n(reset), .i_d(iorq_n),
      .o_q(w_iorq_s), .o_rise(w_iorq_rise), .o_fall(w_iorq_fall)
   );

   z80_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rd (
      .i_clk(clk), .i_rst_n(reset), .i_d(rd_n),
      .o_q(w_rd_s), .o_rise(w_rd_rise), .o_fall(w_rd_fall)
   );

   z80_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wr (
      .i_clk(clk), .i_rst_n(reset), .i_d(wr_n),
      .o_q(w_wr_s), .o_rise(w_wr_rise), .o_fall(w_wr_fall)
   );

   z80_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mreq (
      .i_clk(clk), .i_rst_n(reset), .i_d(mreq_n),
      .o_q(w_mreq_s), .o_rise(w_mreq_rise), .o_fall(w_mreq_fall)
   );

   logic w_iowr_s, w_iord_s;
   logic w_iowr_rise, w_iowr_fall;
   logic w_hit_page, w_hit_ctrl;
   logic w_en;
   logic w_unused;

   logic       r_iowr_d;
   logic       r_hit_page;
   logic       r_hit_ctrl;
   logic [7:0] r_data;
   logic [7:0] r_page;
   logic       r_wp;
   state_t     r_state;

   assign w_iowr_s    = w_iorq_s | w_wr_s;
   assign w_iord_s    = w_iorq_s | w_rd_s;
   assign w_iowr_rise = w_iowr_s & ~r_iowr_d;
   assign w_iowr_fall = ~w_iowr_s & r_iowr_d;

   // Read-side and per-strobe edges are not needed by the datapath.
   assign w_unused = &{w_iord_s, w_iorq_rise, w_iorq_fall,
                       w_rd_rise, w_rd_fall, w_wr_rise,
                       w_wr_fall, w_mreq_fall, r_page};

   assign w_hit_page = (a == PAGE_PORT) & ~a15 & a14;
   assign w_hit_ctrl = (a == CTRL_PORT);
   assign w_en       = r_data[CTL_EN];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_iowr_d   <= 1'b1;
         r_hit_page <= 1'b0;
         r_hit_ctrl <= 1'b0;
         r_data     <= 8'h00;
         r_page     <= 8'h00;
         r_wp       <= 1'b0;
         r_state    <= RST_ST;
      end else begin
         r_iowr_d <= w_iowr_s;
         // Latch address decode and data at the start of the write.
         if (w_iowr_fall) begin
            r_hit_page <= w_hit_page;
            r_hit_ctrl <= w_hit_ctrl;
            r_data     <= d_in;
         end
         if (w_iowr_rise && r_hit_page)
            r_page <= r_data;
         // A control write takes priority over a pending mreq-edge switch.
         if (w_iowr_rise && r_hit_ctrl) begin
            r_wp <= r_data[CTL_WP];
            case (r_state)
               ST_ROM:     if (w_en)  r_state <= ST_ARM_ON;
               ST_ARM_ON:  if (!w_en) r_state <= ST_ROM;
               ST_CACHE:   if (!w_en) r_state <= ST_ARM_OFF;
               ST_ARM_OFF: if (w_en)  r_state <= ST_CACHE;
               default:    r_state <= RST_ST;
            endcase
         end else if (w_mreq_rise) begin
            // Switch only between memory cycles.
            if (r_state == ST_ARM_ON)
               r_state <= ST_CACHE;
            else if (r_state == ST_ARM_OFF)
               r_state <= ST_ROM;
         end
      end
   end

   logic       w_low16k;
   logic [1:0] w_st;

   assign w_st     = r_state;
   assign cache_on = ((r_state == ST_CACHE) | (r_state == ST_ARM_OFF)) ^ jump;
   assign w_low16k = ~a14 & ~a15 & ~mreq_n;
   assign mce      = ~(w_low16k & (~bsrq | cache_on));
   assign moe      = mce | rd_n;
   assign mwe      = mce | wr_n | (r_wp & bsrq & cache_on);
   assign romblk   = cache_on | ~bsrq;
   assign mbank    = r_page[4 +: BANK_W];

   // Gated by reset so readback stays quiet while reset is held.
   assign d_oe  = reset & ~iorq_n & ~rd_n & (w_hit_page | w_hit_ctrl);
   assign d_out = !d_oe      ? 8'h00 :
                  w_hit_page ? r_page :
                               {4'b0000, w_st, r_wp, cache_on};

endmodule

// File: tb/tb_z80_cache_ctl.sv
// Directed self-checking bench for z80_cache_ctl.
// Drives Z80-style bus cycles on negedges and checks strobes/readback.
module tb_z80_cache_ctl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       mreq_n = 1'b1;
   logic       iorq_n = 1'b1;
   logic       rd_n = 1'b1;
   logic       wr_n = 1'b1;
   logic [7:0] a = 8'h00;
   logic       a14 = 1'b0;
   logic       a15 = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic [7:0] d_out;
   logic       d_oe;
   logic       bsrq = 1'b1;
   logic       jump = 1'b0;
   logic       moe, mwe, mce;
   logic [0:0] mbank;
   logic       romblk;
   logic       cache_on;

   int errors = 0;
   int checks = 0;

   logic [7:0] rdv;
   logic       oe;
   logic       c_mce, c_moe, c_mwe;
   logic       mon_en = 1'b0;
   logic       saw_on = 1'b0;

   z80_cache_ctl dut (
      .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n),
      .rd_n(rd_n), .wr_n(wr_n), .a(a), .a14(a14), .a15(a15),
      .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .bsrq(bsrq),
      .jump(jump), .moe(moe), .mwe(mwe), .mce(mce), .mbank(mbank),
      .romblk(romblk), .cache_on(cache_on)
   );

   always #5 clk = ~clk;

   always @(cache_on)
      if (mon_en && cache_on === 1'b1) saw_on = 1'b1;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic setaddr(input logic [15:0] ad);
      a   = ad[7:0];
      a14 = ad[14];
      a15 = ad[15];
   endtask

   task automatic io_wr(input logic [15:0] ad, input logic [7:0] d);
      @(negedge clk);
      setaddr(ad);
      d_in = d;
      @(negedge clk);
      iorq_n = 1'b0;
      wr_n   = 1'b0;
      repeat (4) @(negedge clk);
      iorq_n = 1'b1;
      wr_n   = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic io_rd(input logic [15:0] ad, output logic [7:0] d,
                        output logic o);
      @(negedge clk);
      setaddr(ad);
      iorq_n = 1'b0;
      rd_n   = 1'b0;
      #1;
      d = d_out;
      o = d_oe;
      @(negedge clk);
      iorq_n = 1'b1;
      rd_n   = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic mem(input logic [15:0] ad, input logic wr,
                      output logic o_mce, output logic o_moe,
                      output logic o_mwe);
      @(negedge clk);
      setaddr(ad);
      mreq_n = 1'b0;
      if (wr) wr_n = 1'b0;
      else    rd_n = 1'b0;
      #1;
      o_mce = mce;
      o_moe = moe;
      o_mwe = mwe;
      @(negedge clk);
      mreq_n = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      // Reset held: readback must stay off even with a page read strobe.
      repeat (2) @(negedge clk);
      setaddr(16'h7FFD);
      iorq_n = 1'b0;
      rd_n   = 1'b0;
      #1;
      chk("rst_d_oe", {7'b0, d_oe}, 8'h00);
      chk("rst_d_out", d_out, 8'h00);
      @(negedge clk);
      iorq_n = 1'b1;
      rd_n   = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // ROM state after reset
      mem(16'h0100, 1'b0, c_mce, c_moe, c_mwe);
      chk("rom_mce", {7'b0, c_mce}, 8'h01);
      chk("rom_moe", {7'b0, c_moe}, 8'h01);
      chk("rom_romblk", {7'b0, romblk}, 8'h00);
      chk("rom_mbank", {7'b0, mbank}, 8'h00);
      io_rd(16'h00FB, rdv, oe);
      chk("rom_ctrl_rb", rdv, 8'h00);

      // Paging register
      io_wr(16'h7FFD, 8'h55);
      io_rd(16'h7FFD, rdv, oe);
      chk("page_rb", rdv, 8'h55);
      chk("page_oe", {7'b0, oe}, 8'h01);
      chk("page_mbank", {7'b0, mbank}, 8'h01);

      // Arm cache on
      io_wr(16'h00FB, 8'h01);
      io_rd(16'h00FB, rdv, oe);
      chk("arm_on_rb", rdv, 8'h04);
      chk("arm_on_romblk", {7'b0, romblk}, 8'h00);
      mem(16'h0100, 1'b0, c_mce, c_moe, c_mwe);
      chk("arm_on_mce", {7'b0, c_mce}, 8'h01);
      io_rd(16'h00FB, rdv, oe);
      chk("cache_rb", rdv, 8'h09);
      chk("cache_romblk", {7'b0, romblk}, 8'h01);
      mem(16'h2000, 1'b0, c_mce, c_moe, c_mwe);
      chk("cache_rd_mce", {7'b0, c_mce}, 8'h00);
      chk("cache_rd_moe", {7'b0, c_moe}, 8'h00);

      // Write-protect
      io_wr(16'h00FB, 8'h03);
      io_rd(16'h00FB, rdv, oe);
      chk("wp_rb", rdv, 8'h0B);
      mem(16'h1000, 1'b1, c_mce, c_moe, c_mwe);
      chk("wp_wr_mce", {7'b0, c_mce}, 8'h00);
      chk("wp_wr_mwe", {7'b0, c_mwe}, 8'h01);
      mem(16'h1000, 1'b0, c_mce, c_moe, c_mwe);
      chk("wp_rd_moe", {7'b0, c_moe}, 8'h00);
      bsrq = 1'b0;
      mem(16'h1000, 1'b1, c_mce, c_moe, c_mwe);
      chk("pass_mwe", {7'b0, c_mwe}, 8'h00);
      chk("pass_romblk", {7'b0, romblk}, 8'h01);
      bsrq = 1'b1;

      // Cache off via ARM_OFF
      io_wr(16'h00FB, 8'h02);
      io_rd(16'h00FB, rdv, oe);
      chk("arm_off_rb", rdv, 8'h0F);
      mem(16'h0100, 1'b0, c_mce, c_moe, c_mwe);
      chk("arm_off_mce", {7'b0, c_mce}, 8'h00);
      io_rd(16'h00FB, rdv, oe);
      chk("off_rb", rdv, 8'h02);

      // On then off with no memory cycle
      mon_en = 1'b1;
      io_wr(16'h00FB, 8'h01);
      io_wr(16'h00FB, 8'h00);
      mon_en = 1'b0;
      io_rd(16'h00FB, rdv, oe);
      chk("cancel_rb", rdv, 8'h00);
      chk("cancel_glitch", {7'b0, saw_on}, 8'h00);

      // Bank bit clear
      io_wr(16'h7FFD, 8'h20);
      chk("bank0_mbank", {7'b0, mbank}, 8'h00);

      // Jumper inverts source
      jump = 1'b1;
      @(negedge clk);
      chk("jump_cache_on", {7'b0, cache_on}, 8'h01);
      chk("jump_romblk", {7'b0, romblk}, 8'h01);
      mem(16'h0100, 1'b0, c_mce, c_moe, c_mwe);
      chk("jump_mce", {7'b0, c_mce}, 8'h00);
      io_rd(16'h00FB, rdv, oe);
      chk("jump_rb", rdv, 8'h01);

      // Reset during an I/O write
      @(negedge clk);
      setaddr(16'h7FFD);
      d_in = 8'hFF;
      @(negedge clk);
      iorq_n = 1'b0;
      wr_n   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      iorq_n = 1'b1;
      wr_n   = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      io_rd(16'h7FFD, rdv, oe);
      chk("rstwr_page_rb", rdv, 8'h00);
      chk("rstwr_mbank", {7'b0, mbank}, 8'h00);
      io_rd(16'h00FB, rdv, oe);
      chk("rstwr_ctrl_rb", rdv, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/z80_cache_ctl.md
Name: z80_cache_ctl

Overview:
- Clocked, parametrised successor of the Z80 debug-board cache/ROM-block logic.
- Decodes Z80 I/O cycles for a 7FFD-style paging register and a control port.
- Drives the cache SRAM strobes and bank lines, and blocks the stock ROM while the cache is active.
- Adds multi-bank select, cache write-protect, register readback, and glitch-free cache on/off switching.

Parameters:
- BANK_W, 1: width of the SRAM bank output `mbank` (1..4); taken from `page_reg[4 +: BANK_W]`.
- CTRL_PORT, 8'hFB: low address byte of the control port.
- PAGE_PORT, 8'hFD: low address byte of the paging port; also requires A15=0, A14=1.
- CACHE_ON_RESET, 0: when 1, the FSM resets to CACHE instead of ROM.
- SYNC_STAGES, 2: synchroniser depth for `iorq_n`, `rd_n`, `wr_n`, `mreq_n` (2..3).

Ports:
- clk  in  1  board clock, at least 4x the Z80 clock.
- reset  in  1  asynchronous, active-low reset.
- mreq_n  in  1  Z80 MREQ.
- iorq_n  in  1  Z80 IORQ.
- rd_n  in  1  Z80 RD.
- wr_n  in  1  Z80 WR.
- a  in  8  Z80 A[7:0].
- a14  in  1  Z80 A14.
- a15  in  1  Z80 A15.
- d_in  in  8  Z80 data bus, input side.
- d_out  out  8  readback data.
- d_oe  out  1  drive enable for `d_out`; the top level instantiates the tristate.
- bsrq  in  1  bus-request qualifier; 0 means the cache is passed through unconditionally.
- jump  in  1  board jumper; inverts the effective cache source.
- moe  out  1  SRAM output enable, active-low.
- mwe  out  1  SRAM write enable, active-low.
- mce  out  1  SRAM chip enable, active-low.
- mbank  out  BANK_W  SRAM bank select.
- romblk  out  1  stock-ROM block, active-low.
- cache_on  out  1  effective cache source, for status.

Behaviour:
- Reset (reset=0, asynchronous), all values hold for as long as reset is low:
  - `page_reg` = 0; `wp` = 0.
  - FSM = ROM, or CACHE if CACHE_ON_RESET=1.
  - `d_oe` = 0; `d_out` = 0.
  - Synchroniser flops are set to 1 (inactive).
- Synchronisation:
  - `iorq_n`, `rd_n`, `wr_n`, `mreq_n` each pass through SYNC_STAGES flops.
  - `iowr_s` = `iorq_s` | `wr_s`; `iord_s` = `iorq_s` | `rd_s`.
  - Commit event = rising edge of `iowr_s` (end of an I/O write).
  - Register update happens SYNC_STAGES+1 clocks after the CPU deasserts WR.
- Address decode (combinational on raw inputs):
  - `hit_page` = (a==PAGE_PORT) & ~a15 & a14.
  - `hit_ctrl` = (a==CTRL_PORT).
  - The address is sampled into a register on the falling edge of `iowr_s`; the commit uses the registered address and registered data.
- Writes:
  - Page port: `page_reg` <= `d_in`.
  - Control port:
    - d[0] = requested enable; d[1] = `wp`, which takes effect immediately.
    - d[7:2] are ignored.
- FSM states:
  - ROM.
  - ARM_ON: a control write with d[0]=1 arrived in ROM.
  - CACHE.
  - ARM_OFF: a control write with d[0]=0 arrived in CACHE.
- FSM transitions:
  - ARM_ON -> CACHE, and ARM_OFF -> ROM, on the next rising edge of `mreq_s`. The switch therefore never lands inside a memory cycle.
  - A contrary request while armed returns to the prior state (ARM_ON + d0=0 -> ROM; ARM_OFF + d0=1 -> CACHE) with no mreq wait.
  - A repeated identical request is ignored.
- Outputs:
  - `cache_on` = (state==CACHE | state==ARM_OFF) ^ `jump`.
  - `low16k` = ~a14 & ~a15 & ~mreq_n.
  - `mce` = ~(`low16k` & (~bsrq | `cache_on`)).
  - `moe` = `mce` | `rd_n`.
  - `mwe` = `mce` | `wr_n` | (`wp` & bsrq & `cache_on`). Write-protect applies only when bsrq=1; in pass-through mode (bsrq=0) writes are never blocked.
  - `romblk` = `cache_on` | ~bsrq.
  - `mbank` = `page_reg[4 +: BANK_W]`.
  - The SRAM strobes are combinational so they meet Z80 memory timing.
- Readback (combinational decode on raw strobes, like the strobes above):
  - `d_oe` = 1 while ~iorq_n & ~rd_n & (`hit_page` | `hit_ctrl`).
  - Page port returns `page_reg`.
  - Control port returns {4'b0, `state`[1:0], `wp`, `cache_on`}.
  - If both ports hit, the page port has priority.
- Reset mid-cycle: outputs return to reset values at once; a partial I/O write is discarded.

Decomposition:
- Package `z80db_pkg`:
  - state enum with encodings ROM=2'b00, ARM_ON=2'b01, CACHE=2'b10, ARM_OFF=2'b11;
  - default port constants;
  - control-bit index constants.
- Sub-module `z80_sync_edge`: parametrised SYNC_STAGES synchroniser with rise/fall pulse outputs, one instance per strobe.

Test Plan:
- Reset release, bsrq=1, jump=0, memory read at 0x0100:
  - `mce`=0 only if cache is on; `romblk`=0; `mbank`=0.
- I/O write 0x55 to 0x7FFD, then I/O read of 0x7FFD:
  - read returns 0x55; `mbank`=1 (BANK_W=1, bit4=1); with BANK_W=2, `mbank`=2'b01.
- Control write 0x01 to 0xFB:
  - state = ARM_ON, `romblk` stays 0;
  - after the next mreq_n rising edge, state = CACHE and `romblk`=1;
  - a memory read at 0x2000 gives `mce`=0, `moe`=0.
- In CACHE, control write 0x03, then memory write at 0x1000:
  - `mwe` stays 1 throughout; `moe` still works for reads;
  - control readback = 0x0B (state=CACHE, wp=1, cache_on=1);
  - repeat with bsrq=0: `mwe` asserts (0) during the write, since write-protect does not apply in pass-through.
- Write 0x01 then 0x00 to 0xFB with no memory cycle between:
  - state returns to ROM, `cache_on` never pulses.
- jump=1 with state ROM:
  - `cache_on`=1, `romblk`=1;
  - assert reset during an I/O write: `page_reg` stays 0.
